// File: rtl/paper_sequencer_pkg.sv
// Shared definitions for the paper sequencer: FSM states, instruction field positions, PC width default.
package paper_sequencer_pkg;

    localparam int PC_W_DEF = 4;

    localparam int HALT_BIT = 3;
    localparam int A1_BIT   = 2;
    localparam int A0_BIT   = 1;
    localparam int S_BIT    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/paper_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and the memory (slave).
interface paper_sequencer_if import paper_sequencer_pkg::*; #(
    parameter int PC_W = PC_W_DEF
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [3:0]      instr;

    modport master (output imem_addr, output imem_req, input imem_ack, input instr);
    modport slave  (input imem_addr, input imem_req, output imem_ack, output instr);
endinterface

// File: rtl/paper_sequencer_data_reg.sv
// 2-bit data register with write enable.
// Latency: q updates one edge after we; no backpressure.
module data_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] d,
    output logic [1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 2'b00;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/paper_sequencer.sv
// Fetch/execute sequencer: fetches 4-bit instructions, drives data-stage controls, halts on IR[3].
// Latency: start->FETCH 1 edge, ack->EXEC 1 edge, EXEC->data write 1 edge; fetch stalls while imem_ack low.
module paper_sequencer import paper_sequencer_pkg::*; #(
    parameter int PC_W = PC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    paper_sequencer_if.master       imem,
    output logic                    a1,
    output logic                    a0,
    output logic                    s,
    output logic                    data1,
    output logic                    data0,
    input  logic                    d1,
    input  logic                    d0,
    output logic                    halted
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [3:0]      ir;
    logic [1:0]      data_q;

    logic            req;
    logic            pc_clr;
    logic            pc_inc;
    logic            ir_ld;
    logic            data_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (imem.imem_ack) state_nxt = EXEC;
            EXEC:    state_nxt = ir[HALT_BIT] ? HALT : FETCH;
            HALT:    if (start) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // start only matters in IDLE/HALT; imem_ack only matters in FETCH
    always_comb begin
        req     = 1'b0;
        pc_clr  = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        data_we = 1'b0;
        halted  = 1'b0;
        case (state)
            IDLE: begin
                pc_clr = start;
            end
            FETCH: begin
                req   = 1'b1;
                ir_ld = imem.imem_ack;
            end
            EXEC: begin
                pc_inc  = ~ir[HALT_BIT];
                data_we = ~ir[HALT_BIT];
            end
            HALT: begin
                halted = 1'b1;
                pc_clr = start;
            end
            default: begin
                req = 1'b0;
            end
        endcase
    end

    // PC wraps naturally at 2^PC_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (pc_clr) begin
            pc <= '0;
        end else if (pc_inc) begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 4'h0;
        end else if (ir_ld) begin
            ir <= imem.instr;
        end
    end

    data_reg u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (data_we),
        .d     ({d1, d0}),
        .q     (data_q)
    );

    assign imem.imem_addr = pc;
    assign imem.imem_req  = req;
    assign a1             = ir[A1_BIT];
    assign a0             = ir[A0_BIT];
    assign s              = ir[S_BIT];
    assign data1          = data_q[1];
    assign data0          = data_q[0];

endmodule

// File: tb/tb_paper_sequencer.sv
// Self-checking bench for paper_sequencer: directed vector table, reset/wrap sequences, random run against a model.
module tb_paper_sequencer;
    import paper_sequencer_pkg::*;

    localparam int PC_W = 4;

    logic clk;
    logic rst_n;
    logic start;
    logic a1, a0, s, data1, data0, d1, d0, halted;

    paper_sequencer_if #(.PC_W(PC_W)) bus ();

    paper_sequencer #(.PC_W(PC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .imem   (bus.master),
        .a1     (a1),
        .a0     (a0),
        .s      (s),
        .data1  (data1),
        .data0  (data0),
        .d1     (d1),
        .d0     (d0),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model: mode 0 idle, 1 waiting for instruction, 2 executing, 3 stopped
    int         m_mode;
    int         m_pc;
    logic [3:0] m_ir;
    logic [1:0] m_data;

    typedef struct {
        logic       st;
        logic       ack;
        logic [3:0] ins;
        logic [1:0] d;
        logic       req;
        logic [3:0] addr;
        logic [2:0] ctl;
        logic [1:0] dat;
        logic       hlt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_ir   = 4'h0;
        m_data = 2'b00;
    endtask

    task automatic model_step();
        case (m_mode)
            0: if (start) begin m_mode = 1; m_pc = 0; end
            1: if (bus.imem_ack) begin m_ir = bus.instr; m_mode = 2; end
            2: begin
                if (m_ir[3]) begin
                    m_mode = 3;
                end else begin
                    m_data = {d1, d0};
                    m_pc   = (m_pc + 1) % (1 << PC_W);
                    m_mode = 1;
                end
            end
            default: if (start) begin m_mode = 1; m_pc = 0; end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_req"},    int'(bus.imem_req), int'(m_mode == 1));
        chk({tag, "_addr"},   int'(bus.imem_addr), m_pc);
        chk({tag, "_ctl"},    int'({a1, a0, s}), int'(m_ir[2:0]));
        chk({tag, "_data"},   int'({data1, data0}), int'(m_data));
        chk({tag, "_halted"}, int'(halted), int'(m_mode == 3));
    endtask

    task automatic chk_vals(input string tag, input logic req, input int addr,
                            input logic [2:0] ctl, input logic [1:0] dat, input logic hlt);
        chk({tag, "_req"},    int'(bus.imem_req), int'(req));
        chk({tag, "_addr"},   int'(bus.imem_addr), addr);
        chk({tag, "_ctl"},    int'({a1, a0, s}), int'(ctl));
        chk({tag, "_data"},   int'({data1, data0}), int'(dat));
        chk({tag, "_halted"}, int'(halted), int'(hlt));
    endtask

    initial begin
        //               st ack ins    d      req addr ctl    dat    hlt
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 2'b00, 1'b1, 4'd0, 3'b000, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'h5, 2'b10, 1'b0, 4'd0, 3'b101, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 2'b10, 1'b1, 4'd1, 3'b101, 2'b10, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'd1, 3'b101, 2'b10, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'd1, 3'b101, 2'b10, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'd1, 3'b101, 2'b10, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'h3, 2'b01, 1'b0, 4'd1, 3'b011, 2'b10, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 2'b01, 1'b1, 4'd2, 3'b011, 2'b01, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'h8, 2'b11, 1'b0, 4'd2, 3'b000, 2'b01, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 2'b11, 1'b0, 4'd2, 3'b000, 2'b01, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'h5, 2'b11, 1'b0, 4'd2, 3'b000, 2'b01, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 4'h0, 2'b00, 1'b1, 4'd0, 3'b000, 2'b01, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'hE, 2'b00, 1'b0, 4'd0, 3'b110, 2'b01, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'h0, 2'b10, 1'b0, 4'd0, 3'b110, 2'b01, 1'b1};

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.imem_ack = 1'b0;
        bus.instr    = 4'h0;
        d1           = 1'b0;
        d0           = 1'b0;
        model_reset();
        #1;
        chk_vals("reset", 1'b0, 0, 3'b000, 2'b00, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk_vals("idle", 1'b0, 0, 3'b000, 2'b00, 1'b0);

        // directed program: zero-wait, wait states, ignored start, halt, restart
        for (int i = 0; i < 14; i++) begin
            start        = tbl[i].st;
            bus.imem_ack = tbl[i].ack;
            bus.instr    = tbl[i].ins;
            {d1, d0}     = tbl[i].d;
            cycle();
            chk_vals($sformatf("vec%0d", i), tbl[i].req, int'(tbl[i].addr),
                     tbl[i].ctl, tbl[i].dat, tbl[i].hlt);
        end

        // reset asserted mid-EXEC
        start = 1'b1; bus.imem_ack = 1'b0;
        cycle();
        start = 1'b0; bus.imem_ack = 1'b1; bus.instr = 4'h7; {d1, d0} = 2'b11;
        cycle();
        chk("midexec_ctl", int'({a1, a0, s}), 7);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_vals("rst_midexec", 1'b0, 0, 3'b000, 2'b00, 1'b0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_vals($sformatf("idle_ack%0d", i), 1'b0, 0, 3'b000, 2'b00, 1'b0);
        end

        // PC wrap over 16 non-halt instructions
        start = 1'b1; bus.imem_ack = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wrap_addr%0d", i), int'(bus.imem_addr), i);
            bus.imem_ack = 1'b1; bus.instr = 4'h1; {d1, d0} = 2'(i);
            cycle();
            bus.imem_ack = 1'b0;
            cycle();
        end
        chk("wrap_addr_end", int'(bus.imem_addr), 0);
        chk("wrap_data", int'({data1, data0}), 3);
        chk("wrap_req", int'(bus.imem_req), 1);

        // random run against the model
        for (int i = 0; i < 800; i++) begin
            start        = ($urandom_range(0, 9) == 0);
            bus.imem_ack = $urandom_range(0, 1) == 1;
            bus.instr    = {($urandom_range(0, 7) == 0), 3'($urandom)};
            d1           = 1'($urandom);
            d0           = 1'($urandom);
            cycle();
            chk_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paper_sequencer.md
PAPER_SEQUENCER -- requirements
Module: paper_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 4, program-counter width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  begin or restart program execution.
REQ-005 SHALL have port imem_addr  output  PC_W  instruction address, equal to PC.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_ack  input  1  instruction valid on instr this cycle.
REQ-008 SHALL have port instr  input  4  instruction: [3] halt, [2] a1, [1] a0, [0] s.
REQ-009 SHALL have ports a1, a0, s  output  1 each  control inputs to the data next-state stage.
REQ-010 SHALL have ports data1, data0  output  1 each  registered 2-bit data value, fed back to the data stage.
REQ-011 SHALL have ports d1, d0  input  1 each  next-state data from the data stage.
REQ-012 SHALL have port halted  output  1  high while in HALT.

Function
REQ-013 FSM SHALL have states IDLE, FETCH, EXEC, HALT.
REQ-014 IDLE: start=1 -> FETCH and PC cleared to 0; otherwise stay in IDLE.
REQ-015 FETCH: imem_req=1; on imem_ack=1, latch instr into IR at the same edge and go to EXEC; otherwise stay in FETCH with imem_req held high.
REQ-016 EXEC, IR[3]=0: latch {d1,d0} into {data1,data0}, increment PC, go to FETCH, all at one edge.
REQ-017 EXEC, IR[3]=1: data register unchanged, PC unchanged, go to HALT.
REQ-018 HALT: halted=1; start=1 -> FETCH with PC cleared to 0; data register retained.
REQ-019 a1, a0, s SHALL equal IR[2:0] combinationally in every state, so they are stable throughout EXEC.
REQ-020 imem_req SHALL be high only in FETCH; imem_ack outside FETCH SHALL be ignored.
REQ-021 start SHALL be ignored in FETCH and EXEC.
REQ-022 PC SHALL wrap from 2^PC_W-1 to 0 without a flag; imem_addr SHALL equal PC at all times.
REQ-023 Latency with zero-wait ack: start at edge N -> FETCH after N; instr latched at N+1; data register updated at N+2. One instruction completes every 2 cycles.
REQ-024 data1/data0 SHALL change only at an EXEC edge (REQ-016) or on reset.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, PC=0, IR=0, data1=data0=0, imem_req=0, halted=0, a1=a0=s=0.
REQ-026 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the instruction with no data-register write; after release the block waits in IDLE for start.

Structure
REQ-027 A shared package SHALL hold the state enumeration, the instruction field bit positions (HALT_BIT=3, A1_BIT=2, A0_BIT=1, S_BIT=0) and the PC_W default.
REQ-028 The 2-bit data register with write-enable SHALL be a sub-module named data_reg; FSM, PC and IR stay in paper_sequencer.

Verification
(bench drives d1/d0 directly and does not instantiate the data stage)
REQ-029 Reset: assert rst_n=0 mid-EXEC -> all outputs 0 in the same cycle; state IDLE after release; no write.
REQ-030 Zero-wait program: instr 0x5 at addr 0 with {d1,d0}=2'b10 -> a1a0s=101 during EXEC; data1data0=10 at cycle start+2; imem_addr=1 next.
REQ-031 Wait states: imem_ack delayed 3 cycles -> imem_req high 4 cycles; imem_addr constant; no data-register change.
REQ-032 Halt: instr 0x8 at addr 2 -> halted=1; PC stays 2; data register unchanged; start -> FETCH at addr 0, halted=0.
REQ-033 Wrap: 16 non-halt instrs with PC_W=4 -> imem_addr goes 15 then 0.
REQ-034 Ignored inputs: start pulse in EXEC and imem_ack in IDLE -> no state or PC change.
